// File: rtl/alu_reservation_station.sv
// ALU reservation station: buffers dispatched ALU/branch ops until both
// operands are known, snoops result broadcasts, issues one ready op per cycle.
module alu_reservation_station #(
    parameter int RS_SIZE       = 16,
    parameter int IDWidth       = 32,
    parameter int ROBWidth      = 4,
    parameter int AddressWidth  = 32,
    parameter int InstTypeWidth = 6,
    parameter logic [InstTypeWidth-1:0] NOP = '0
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     dispatch_rs_en_in,
    input  logic [InstTypeWidth-1:0] dispatch_opcode_in,
    input  logic [IDWidth-1:0]       dispatch_vj_in,
    input  logic [ROBWidth-1:0]      dispatch_qj_in,
    input  logic [IDWidth-1:0]       dispatch_vk_in,
    input  logic [ROBWidth-1:0]      dispatch_qk_in,
    input  logic [IDWidth-1:0]       dispatch_a_in,
    input  logic [AddressWidth-1:0]  dispatch_pc_in,
    input  logic [ROBWidth-1:0]      dispatch_dest_in,
    output logic                     rs_full_out,
    input  logic [ROBWidth-1:0]      alu_rs_h_in,
    input  logic [IDWidth-1:0]       alu_rs_result_in,
    input  logic [ROBWidth-1:0]      lsb_rs_h_in,
    input  logic [IDWidth-1:0]       lsb_rs_result_in,
    input  logic                     rob_rs_rst_in,
    output logic [InstTypeWidth-1:0] rs_alu_opcode_out,
    output logic [IDWidth-1:0]       rs_alu_vj_out,
    output logic [IDWidth-1:0]       rs_alu_vk_out,
    output logic [IDWidth-1:0]       rs_alu_a_out,
    output logic [AddressWidth-1:0]  rs_alu_pc_out,
    output logic [ROBWidth-1:0]      rs_alu_dest_out
);
    localparam int IW = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
    localparam int CW = $clog2(RS_SIZE + 1);

    logic [RS_SIZE-1:0]       busy;
    logic [InstTypeWidth-1:0] op   [RS_SIZE];
    logic [IDWidth-1:0]       vj   [RS_SIZE];
    logic [ROBWidth-1:0]      qj   [RS_SIZE];
    logic [IDWidth-1:0]       vk   [RS_SIZE];
    logic [ROBWidth-1:0]      qk   [RS_SIZE];
    logic [IDWidth-1:0]       a    [RS_SIZE];
    logic [AddressWidth-1:0]  pc   [RS_SIZE];
    logic [ROBWidth-1:0]      dest [RS_SIZE];

    logic [IW-1:0]       free_idx;
    logic [IW-1:0]       sel_idx;
    logic                sel_found;
    logic [CW-1:0]       count;
    logic                full;
    logic                flush;
    logic [IDWidth-1:0]  d_vj;
    logic [IDWidth-1:0]  d_vk;
    logic [ROBWidth-1:0] d_qj;
    logic [ROBWidth-1:0] d_qk;

    // Scan from the top down so the lowest matching index is the last one kept.
    always_comb begin
        free_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        count     = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IW'(i);
            if (busy[i] && qj[i] == '0 && qk[i] == '0) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
            count = count + CW'(busy[i]);
        end
    end

    assign full        = (count == CW'(RS_SIZE));
    assign rs_full_out = full;
    assign flush       = rst_in || rob_rs_rst_in;

    // Operands produced in the dispatch cycle are captured straight off the bus.
    always_comb begin
        d_vj = dispatch_vj_in;
        d_qj = dispatch_qj_in;
        d_vk = dispatch_vk_in;
        d_qk = dispatch_qk_in;
        if (dispatch_qj_in != '0 && dispatch_qj_in == alu_rs_h_in) begin
            d_vj = alu_rs_result_in;
            d_qj = '0;
        end else if (dispatch_qj_in != '0 && dispatch_qj_in == lsb_rs_h_in) begin
            d_vj = lsb_rs_result_in;
            d_qj = '0;
        end
        if (dispatch_qk_in != '0 && dispatch_qk_in == alu_rs_h_in) begin
            d_vk = alu_rs_result_in;
            d_qk = '0;
        end else if (dispatch_qk_in != '0 && dispatch_qk_in == lsb_rs_h_in) begin
            d_vk = lsb_rs_result_in;
            d_qk = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (flush) begin
            busy              <= '0;
            rs_alu_opcode_out <= NOP;
            rs_alu_vj_out     <= '0;
            rs_alu_vk_out     <= '0;
            rs_alu_a_out      <= '0;
            rs_alu_pc_out     <= '0;
            rs_alu_dest_out   <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i]) begin
                    if (qj[i] != '0 && qj[i] == alu_rs_h_in) begin
                        vj[i] <= alu_rs_result_in;
                        qj[i] <= '0;
                    end else if (qj[i] != '0 && qj[i] == lsb_rs_h_in) begin
                        vj[i] <= lsb_rs_result_in;
                        qj[i] <= '0;
                    end
                    if (qk[i] != '0 && qk[i] == alu_rs_h_in) begin
                        vk[i] <= alu_rs_result_in;
                        qk[i] <= '0;
                    end else if (qk[i] != '0 && qk[i] == lsb_rs_h_in) begin
                        vk[i] <= lsb_rs_result_in;
                        qk[i] <= '0;
                    end
                end
            end
            if (sel_found) begin
                busy[sel_idx]     <= 1'b0;
                rs_alu_opcode_out <= op[sel_idx];
                rs_alu_vj_out     <= vj[sel_idx];
                rs_alu_vk_out     <= vk[sel_idx];
                rs_alu_a_out      <= a[sel_idx];
                rs_alu_pc_out     <= pc[sel_idx];
                rs_alu_dest_out   <= dest[sel_idx];
            end else begin
                rs_alu_opcode_out <= NOP;
            end
            // The free slot is never busy, so it cannot collide with wake-up or issue.
            if (dispatch_rs_en_in && !full) begin
                busy[free_idx] <= 1'b1;
                op[free_idx]   <= dispatch_opcode_in;
                vj[free_idx]   <= d_vj;
                qj[free_idx]   <= d_qj;
                vk[free_idx]   <= d_vk;
                qk[free_idx]   <= d_qk;
                a[free_idx]    <= dispatch_a_in;
                pc[free_idx]   <= dispatch_pc_in;
                dest[free_idx] <= dispatch_dest_in;
            end
        end
    end
endmodule

// File: tb/tb_alu_reservation_station.sv
// Bench for alu_reservation_station: directed dispatch/broadcast vectors,
// expected issues queued with their cycle and checked by a separate monitor.
module tb_alu_reservation_station;
    localparam logic [5:0] NOP = 6'd0;
    localparam logic [5:0] ADD = 6'd1;
    localparam logic [5:0] SUB = 6'd2;
    localparam logic [5:0] XOR = 6'd3;
    localparam logic [5:0] BEQ = 6'd4;
    localparam logic [5:0] ORR = 6'd5;
    localparam logic [5:0] AND = 6'd6;
    localparam logic [5:0] SLT = 6'd7;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] a;
        logic [31:0] pc;
        logic [3:0]  dest;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        en;
    logic [5:0]  d_op;
    logic [31:0] d_vj;
    logic [3:0]  d_qj;
    logic [31:0] d_vk;
    logic [3:0]  d_qk;
    logic [31:0] d_a;
    logic [31:0] d_pc;
    logic [3:0]  d_dest;
    logic        full;
    logic [3:0]  alu_h;
    logic [31:0] alu_res;
    logic [3:0]  lsb_h;
    logic [31:0] lsb_res;
    logic        rob_rst;
    logic [5:0]  o_op;
    logic [31:0] o_vj;
    logic [31:0] o_vk;
    logic [31:0] o_a;
    logic [31:0] o_pc;
    logic [3:0]  o_dest;
    logic        rdy_q = 1'b0;
    logic        flush_q = 1'b1;

    alu_reservation_station dut (
        .clk_in             (clk),
        .rst_in             (rst_in),
        .rdy_in             (rdy_in),
        .dispatch_rs_en_in  (en),
        .dispatch_opcode_in (d_op),
        .dispatch_vj_in     (d_vj),
        .dispatch_qj_in     (d_qj),
        .dispatch_vk_in     (d_vk),
        .dispatch_qk_in     (d_qk),
        .dispatch_a_in      (d_a),
        .dispatch_pc_in     (d_pc),
        .dispatch_dest_in   (d_dest),
        .rs_full_out        (full),
        .alu_rs_h_in        (alu_h),
        .alu_rs_result_in   (alu_res),
        .lsb_rs_h_in        (lsb_h),
        .lsb_rs_result_in   (lsb_res),
        .rob_rs_rst_in      (rob_rst),
        .rs_alu_opcode_out  (o_op),
        .rs_alu_vj_out      (o_vj),
        .rs_alu_vk_out      (o_vk),
        .rs_alu_a_out       (o_a),
        .rs_alu_pc_out      (o_pc),
        .rs_alu_dest_out    (o_dest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rdy_q   <= rdy_in;
        flush_q <= rst_in | rob_rst;
    end

    // A fresh issue is present only if the edge that produced it was enabled.
    always @(negedge clk) begin
        if (rdy_q && !flush_q && o_op != NOP) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue op=%0d dest=%0d cyc=%0d",
                         o_op, o_dest, cyc);
            end else begin
                e = sbq.pop_front();
                if (o_op !== e.op || o_vj !== e.vj || o_vk !== e.vk ||
                    o_a !== e.a || o_pc !== e.pc || o_dest !== e.dest ||
                    cyc != e.cyc) begin
                    errors++;
                    $display("FAIL issue got op=%0d vj=%h vk=%h a=%h pc=%h dest=%0d cyc=%0d expected op=%0d vj=%h vk=%h a=%h pc=%h dest=%0d cyc=%0d",
                             o_op, o_vj, o_vk, o_a, o_pc, o_dest, cyc,
                             e.op, e.vj, e.vk, e.a, e.pc, e.dest, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic dispatch(input logic [5:0] op, input logic [31:0] vj,
                            input logic [3:0] qj, input logic [31:0] vk,
                            input logic [3:0] qk, input logic [31:0] a,
                            input logic [31:0] pc, input logic [3:0] dest);
        en = 1'b1; d_op = op; d_vj = vj; d_qj = qj; d_vk = vk; d_qk = qk;
        d_a = a; d_pc = pc; d_dest = dest;
    endtask

    task automatic idle();
        en = 1'b0; d_op = NOP; d_vj = '0; d_qj = '0; d_vk = '0; d_qk = '0;
        d_a = '0; d_pc = '0; d_dest = '0;
    endtask

    task automatic expect_issue(input logic [5:0] op, input logic [31:0] vj,
                                input logic [31:0] vk, input logic [31:0] a,
                                input logic [31:0] pc, input logic [3:0] dest,
                                input int at);
        exp_t x;
        x.op = op; x.vj = vj; x.vk = vk; x.a = a; x.pc = pc; x.dest = dest;
        x.cyc = at;
        sbq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; rob_rst = 1'b0;
        alu_h = '0; alu_res = '0; lsb_h = '0; lsb_res = '0;
        idle();
        ticks(3);
        rst_in = 1'b0;
        chk("rst_opcode", 32'(o_op), 32'(NOP));
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_vj", o_vj, 32'd0);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_dest", 32'(o_dest), 32'd0);

        // ready dispatch issues two cycles later, for one cycle only
        c = cyc;
        dispatch(ADD, 32'd5, 4'd0, 32'd7, 4'd0, 32'h20, 32'h100, 4'd3);
        expect_issue(ADD, 32'd5, 32'd7, 32'h20, 32'h100, 4'd3, c + 2);
        tick(); idle();
        ticks(2);
        chk("t1_nop_after", 32'(o_op), 32'(NOP));
        ticks(2);

        // wake-up from the ALU bus
        c = cyc;
        dispatch(SUB, 32'hDEAD, 4'd2, 32'd3, 4'd0, 32'd0, 32'h104, 4'd6);
        tick(); idle();
        tick();
        alu_h = 4'd2; alu_res = 32'h10;
        expect_issue(SUB, 32'h10, 32'd3, 32'd0, 32'h104, 4'd6, c + 4);
        tick();
        alu_h = '0; alu_res = '0;
        ticks(4);

        // same-cycle bypass from the LSB bus
        c = cyc;
        dispatch(XOR, 32'd1, 4'd0, 32'hBEEF, 4'd4, 32'h8, 32'h108, 4'd7);
        lsb_h = 4'd4; lsb_res = 32'd9;
        expect_issue(XOR, 32'd1, 32'd9, 32'h8, 32'h108, 4'd7, c + 2);
        tick(); idle();
        lsb_h = '0; lsb_res = '0;
        ticks(4);

        // fill every slot on tag 5, then release them all at once
        c = cyc;
        for (int i = 0; i < 16; i++) begin
            dispatch(BEQ, 32'h1000 + 32'(i), 4'd5, 32'(i), 4'd0,
                     32'(i * 4), 32'h200 + 32'(i * 4), 4'((i % 15) + 1));
            tick();
        end
        chk("t4_full", 32'(full), 32'd1);
        dispatch(ADD, 32'd1, 4'd0, 32'd1, 4'd0, 32'd0, 32'h2FC, 4'd9);
        alu_h = 4'd5; alu_res = 32'h55;
        for (int i = 0; i < 16; i++)
            expect_issue(BEQ, 32'h55, 32'(i), 32'(i * 4),
                         32'h200 + 32'(i * 4), 4'((i % 15) + 1), c + 18 + i);
        tick(); idle();
        alu_h = '0; alu_res = '0;
        chk("t4_full_hold", 32'(full), 32'd1);
        tick();
        chk("t4_full_drop", 32'(full), 32'd0);
        ticks(20);

        // flush with three waiting entries and one issuing
        dispatch(ADD, 32'd0, 4'd7, 32'd1, 4'd0, 32'd0, 32'h300, 4'd1);
        tick();
        dispatch(ADD, 32'd0, 4'd8, 32'd1, 4'd0, 32'd0, 32'h304, 4'd2);
        tick();
        dispatch(ADD, 32'd0, 4'd9, 32'd1, 4'd0, 32'd0, 32'h308, 4'd4);
        tick();
        dispatch(ORR, 32'd1, 4'd0, 32'd2, 4'd0, 32'd0, 32'h30C, 4'd5);
        tick();
        rob_rst = 1'b1;
        dispatch(AND, 32'd3, 4'd0, 32'd4, 4'd0, 32'd0, 32'h310, 4'd6);
        tick(); idle();
        rob_rst = 1'b0;
        chk("t5_flush_nop", 32'(o_op), 32'(NOP));
        chk("t5_flush_full", 32'(full), 32'd0);
        alu_h = 4'd7; alu_res = 32'h1; lsb_h = 4'd8; lsb_res = 32'h2;
        tick();
        alu_h = 4'd9; lsb_h = '0; lsb_res = '0;
        tick();
        alu_h = '0; alu_res = '0;
        ticks(5);

        // freeze with rdy_in low across a broadcast and a dispatch attempt
        c = cyc;
        dispatch(SLT, 32'd0, 4'd11, 32'd1, 4'd0, 32'd0, 32'h400, 4'd1);
        tick();
        dispatch(ADD, 32'h11, 4'd0, 32'h22, 4'd0, 32'h4, 32'h404, 4'd2);
        expect_issue(ADD, 32'h11, 32'h22, 32'h4, 32'h404, 4'd2, c + 3);
        tick();
        dispatch(SUB, 32'h33, 4'd0, 32'h44, 4'd0, 32'd0, 32'h408, 4'd3);
        expect_issue(SUB, 32'h33, 32'h44, 32'd0, 32'h408, 4'd3, c + 7);
        tick(); idle();
        rdy_in = 1'b0;
        tick();
        alu_h = 4'd11; alu_res = 32'hAA;
        dispatch(AND, 32'd5, 4'd0, 32'd6, 4'd0, 32'd0, 32'h40C, 4'd7);
        tick(); idle();
        alu_h = '0; alu_res = '0;
        chk("t6_hold_op", 32'(o_op), 32'(ADD));
        chk("t6_hold_dest", 32'(o_dest), 32'd2);
        tick();
        chk("t6_hold_vj", o_vj, 32'h11);
        chk("t6_hold_pc", o_pc, 32'h404);
        rdy_in = 1'b1;
        tick();
        alu_h = 4'd11; alu_res = 32'h77;
        expect_issue(SLT, 32'h77, 32'd1, 32'd0, 32'h400, 4'd1, c + 9);
        tick();
        alu_h = '0; alu_res = '0;
        ticks(6);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL missing_issues got=%0d pending expected=0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
